// File: rtl/hack_pc_unit_if.sv
// Execute-stage bundle between the Hack datapath and the program-counter unit.
// The slave side is the PC unit; the master side drives instruction/flag inputs.
interface hack_pc_unit_if #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 32
);
  logic [WIDTH-1:0]     a_in;
  logic                 is_c_inst;
  logic [2:0]           jump_bits;
  logic                 zr;
  logic                 ng;
  logic                 exec_valid;
  logic                 stall;
  logic [WIDTH-1:0]     pc;
  logic                 fetch_valid;
  logic                 jump_taken;
  logic                 halted;
  logic [CNT_WIDTH-1:0] retired;

  modport master (
    output a_in, is_c_inst, jump_bits, zr, ng, exec_valid, stall,
    input  pc, fetch_valid, jump_taken, halted, retired
  );

  modport slave (
    input  a_in, is_c_inst, jump_bits, zr, ng, exec_valid, stall,
    output pc, fetch_valid, jump_taken, halted, retired
  );
endinterface

// File: rtl/hack_pc_unit.sv
// Hack CPU program counter with jump resolution, self-loop halt detection
// and a saturating retired-instruction counter. All outputs are registered.
module hack_pc_unit #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter int               CNT_WIDTH  = 32
) (
  input  logic           clk,
  input  logic           reset,
  hack_pc_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     pc_q, pc_d;
  logic                 fetch_valid_q, fetch_valid_d;
  logic                 jump_taken_q, jump_taken_d;
  logic                 halted_q, halted_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 fire_s;
  logic                 taken_s;

  // Hack jump decode: j1=less-than, j2=equal, j3=greater-than; A-instructions never jump.
  function automatic logic jump_cond(input logic       c_inst,
                                     input logic [2:0] jbits,
                                     input logic       zr_f,
                                     input logic       ng_f);
    return c_inst & ((jbits[2] & ng_f) | (jbits[1] & zr_f) |
                     (jbits[0] & ~ng_f & ~zr_f));
  endfunction

  assign fire_s  = bus.exec_valid & ~bus.stall;
  assign taken_s = jump_cond(bus.is_c_inst, bus.jump_bits, bus.zr, bus.ng);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_ADDR;
      fetch_valid_q <= 1'b0;
      jump_taken_q  <= 1'b0;
      halted_q      <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      jump_taken_q  <= jump_taken_d;
      halted_q      <= halted_d;
      retired_q     <= retired_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = fetch_valid_q;
    jump_taken_d  = 1'b0;
    halted_d      = halted_q;
    retired_d     = retired_q;
    case (state_q)
      S_BOOT: begin
        state_d       = S_RUN;
        fetch_valid_d = 1'b1;
      end
      S_RUN: begin
        if (fire_s) begin
          if (retired_q != {CNT_WIDTH{1'b1}}) begin
            retired_d = retired_q + CNT_WIDTH'(1);
          end else begin
            retired_d = retired_q;
          end
          if (taken_s) begin
            jump_taken_d = 1'b1;
            // Jumping to itself can never make progress, so park the core.
            if (bus.a_in == pc_q) begin
              state_d       = S_HALT;
              halted_d      = 1'b1;
              fetch_valid_d = 1'b0;
            end else begin
              pc_d = bus.a_in;
            end
          end else begin
            pc_d = pc_q + WIDTH'(1);
          end
        end else begin
          pc_d = pc_q;
        end
      end
      S_HALT: begin
        fetch_valid_d = 1'b0;
        halted_d      = 1'b1;
      end
      default: begin
        state_d       = S_BOOT;
        pc_d          = RESET_ADDR;
        fetch_valid_d = 1'b0;
        halted_d      = 1'b0;
        retired_d     = '0;
      end
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.jump_taken  = jump_taken_q;
  assign bus.halted      = halted_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_hack_pc_unit.sv
// Self-checking bench for hack_pc_unit: directed sequences, a jump truth table,
// randomized traffic against a behavioural model, and a narrow-counter instance.
module tb_hack_pc_unit;

  logic clk;
  logic reset;
  logic reset2;

  hack_pc_unit_if #(.WIDTH(16), .CNT_WIDTH(32)) bif ();
  hack_pc_unit_if #(.WIDTH(16), .CNT_WIDTH(4))  bif2 ();

  hack_pc_unit #(.WIDTH(16), .RESET_ADDR(16'h0000), .CNT_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  hack_pc_unit #(.WIDTH(16), .RESET_ADDR(16'h0000), .CNT_WIDTH(4)) dut4 (
    .clk   (clk),
    .reset (reset2),
    .bus   (bif2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Behavioural model state
  int unsigned m_pc;
  longint      m_ret;
  bit          m_fv, m_jt, m_halt, m_boot;

  typedef struct {
    logic       c;
    logic [2:0] j;
    logic       zr;
    logic       ng;
    logic       exp_taken;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decision: classify the ALU result as a number and apply the mnemonic.
  function automatic bit ref_taken(bit c, bit [2:0] j, bit zr, bit ng);
    int v;
    v = zr ? 0 : (ng ? -1 : 1);
    if (!c) return 1'b0;
    case (j)
      3'd1:    return v > 0;
      3'd2:    return v == 0;
      3'd3:    return v >= 0;
      3'd4:    return v < 0;
      3'd5:    return v != 0;
      3'd6:    return v <= 0;
      3'd7:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge();
    bit t;
    if (reset) begin
      m_pc = 0; m_fv = 0; m_jt = 0; m_halt = 0; m_ret = 0; m_boot = 1;
    end else if (m_boot) begin
      m_boot = 0; m_fv = 1; m_jt = 0;
    end else if (m_halt) begin
      m_jt = 0;
    end else if (bif.exec_valid && !bif.stall) begin
      t = ref_taken(bif.is_c_inst, bif.jump_bits, bif.zr, bif.ng);
      m_ret = (m_ret == 64'hFFFF_FFFF) ? m_ret : m_ret + 1;
      m_jt  = t;
      if (t && (bif.a_in == m_pc)) begin
        m_halt = 1; m_fv = 0;
      end else if (t) begin
        m_pc = bif.a_in;
      end else begin
        m_pc = (m_pc + 1) % 65536;
      end
    end else begin
      m_jt = 0;
    end
  endtask

  task automatic drive(input bit c, input bit [2:0] j, input bit zr, input bit ng,
                       input bit [15:0] a, input bit ev, input bit st);
    bif.is_c_inst = c; bif.jump_bits = j; bif.zr = zr; bif.ng = ng;
    bif.a_in = a; bif.exec_valid = ev; bif.stall = st;
  endtask

  // One clock: advance the model, let the edge pass, compare every output.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("pc",          64'(bif.pc),          64'(m_pc));
    chk("fetch_valid", 64'(bif.fetch_valid), 64'(m_fv));
    chk("jump_taken",  64'(bif.jump_taken),  64'(m_jt));
    chk("halted",      64'(bif.halted),      64'(m_halt));
    chk("retired",     64'(bif.retired),     64'(m_ret));
  endtask

  task automatic jump_to(input bit [15:0] target);
    drive(1'b1, 3'b111, 1'b0, 1'b0, target, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] truth [8];
    n_tests = 0; n_fail = 0;
    reset = 1'b1; reset2 = 1'b1;
    drive(1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    bif2.is_c_inst = 1'b0; bif2.jump_bits = 3'b000; bif2.zr = 1'b0; bif2.ng = 1'b0;
    bif2.a_in = 16'h0000; bif2.exec_valid = 1'b0; bif2.stall = 1'b0;

    // Expected taken per code for flag cases {eq, lt, gt}
    truth = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111};
    for (int code = 0; code < 8; code++) begin
      tbl.push_back('{1'b1, 3'(code), 1'b1, 1'b0, truth[code][2]});
      tbl.push_back('{1'b1, 3'(code), 1'b0, 1'b1, truth[code][1]});
      tbl.push_back('{1'b1, 3'(code), 1'b0, 1'b0, truth[code][0]});
    end
    tbl.push_back('{1'b0, 3'b111, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 3'b111, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 3'b111, 1'b0, 1'b0, 1'b0});

    // Reset for two cycles, exec_valid high to show it is ignored
    drive(1'b1, 3'b111, 1'b0, 1'b0, 16'h0042, 1'b1, 1'b0);
    cycle(); cycle();
    chk("rst_pc", 64'(bif.pc), 64'h0);
    chk("rst_fv", 64'(bif.fetch_valid), 64'h0);
    chk("rst_halted", 64'(bif.halted), 64'h0);
    chk("rst_retired", 64'(bif.retired), 64'h0);
    reset = 1'b0;
    cycle();
    chk("boot_fv", 64'(bif.fetch_valid), 64'h1);
    chk("boot_pc_ignores_ev", 64'(bif.pc), 64'h0);

    // Five A-instructions with jump bits set
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 3'b111, 1'b0, 1'b0, 16'h0099, 1'b1, 1'b0);
      cycle();
      chk("ainst_pc", 64'(bif.pc), 64'(i));
      chk("ainst_jt", 64'(bif.jump_taken), 64'h0);
    end
    chk("ainst_retired", 64'(bif.retired), 64'd5);

    // JEQ taken then not taken from 0x0010
    jump_to(16'h0010);
    drive(1'b1, 3'b010, 1'b1, 1'b0, 16'h0100, 1'b1, 1'b0);
    cycle();
    chk("jeq_pc", 64'(bif.pc), 64'h0100);
    chk("jeq_jt", 64'(bif.jump_taken), 64'h1);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    cycle();
    chk("jeq_jt_pulse", 64'(bif.jump_taken), 64'h0);
    jump_to(16'h0010);
    drive(1'b1, 3'b010, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0);
    cycle();
    chk("jeq_nt_pc", 64'(bif.pc), 64'h0011);

    // Jump truth table
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].c, tbl[i].j, tbl[i].zr, tbl[i].ng, 16'(16'h0200 + i), 1'b1, 1'b0);
      cycle();
      chk($sformatf("table_jt[%0d]", i), 64'(bif.jump_taken), 64'(tbl[i].exp_taken));
    end

    // Stall holds pc and counter even with exec_valid
    jump_to(16'h0020);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      cycle();
      chk("stall_pc", 64'(bif.pc), 64'h0020);
    end
    drive(1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    cycle();
    chk("stall_release_pc", 64'(bif.pc), 64'h0021);

    // Wrap at top of address space
    jump_to(16'hFFFF);
    drive(1'b1, 3'b000, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0);
    cycle();
    chk("wrap_pc", 64'(bif.pc), 64'h0000);

    // Self-jump halts and stays halted
    jump_to(16'h0030);
    drive(1'b1, 3'b111, 1'b0, 1'b0, 16'h0030, 1'b1, 1'b0);
    cycle();
    chk("halt_flag", 64'(bif.halted), 64'h1);
    chk("halt_fv", 64'(bif.fetch_valid), 64'h0);
    chk("halt_jt", 64'(bif.jump_taken), 64'h1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'b111, 1'b0, 1'b0, 16'h0555, 1'b1, 1'b0);
      cycle();
      chk("halt_pc_frozen", 64'(bif.pc), 64'h0030);
    end
    reset = 1'b1;
    cycle();
    chk("halt_reset_pc", 64'(bif.pc), 64'h0);
    chk("halt_reset_flag", 64'(bif.halted), 64'h0);
    reset = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      int f;
      r = $urandom_range(0, 99);
      reset = (r < 2) || (m_halt && r < 30);
      f = $urandom_range(0, 2);
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            f == 0, f == 1,
            ($urandom_range(0, 7) == 0) ? 16'(m_pc) : 16'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
      cycle();
    end
    reset = 1'b1;
    cycle();

    // Narrow counter saturates at all-ones
    reset2 = 1'b1;
    @(posedge clk); #1;
    reset2 = 1'b0;
    bif2.exec_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 14) chk("sat_14", 64'(bif2.retired), 64'd14);
      if (i == 15) chk("sat_15", 64'(bif2.retired), 64'd15);
    end
    chk("sat_hold", 64'(bif2.retired), 64'hF);
    chk("sat_pc", 64'(bif2.pc), 64'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_pc_unit.md
Name: hack_pc_unit

Overview:
- Program-counter and jump-resolution stage of the Hack CPU.
- Consumes the A register value (loaded through the 16-bit A-input selector), the ALU zr/ng flags and the C-instruction jump bits.
- Produces the next instruction address for ROM, a fetch-valid qualifier, a jump-taken pulse, a sticky halt flag and a retired-instruction counter.

Parameters:
- WIDTH, 16, address/data width of pc and a_in
- RESET_ADDR, 0, pc value loaded on reset
- CNT_WIDTH, 32, width of retired-instruction counter

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- a_in  input  WIDTH  current A register value (jump target)
- is_c_inst  input  1  current instruction is a C-instruction (instr[15])
- jump_bits  input  3  {j1,j2,j3} = instr[2:0]
- zr  input  1  ALU output == 0
- ng  input  1  ALU output < 0
- exec_valid  input  1  current instruction completes execution this cycle
- stall  input  1  memory wait; freeze pc and counter
- pc  output  WIDTH  address of instruction being fetched/executed
- fetch_valid  output  1  pc is a valid fetch address
- jump_taken  output  1  one-cycle pulse: previous retire loaded pc from a_in
- halted  output  1  sticky: self-jump loop detected
- retired  output  CNT_WIDTH  count of retired instructions, saturating

Behaviour:
- Reset:
  - Synchronous; wins over every other input in the same cycle.
  - State -> S_BOOT; pc=RESET_ADDR, fetch_valid=0, jump_taken=0, halted=0, retired=0.
- FSM states: S_BOOT, S_RUN, S_HALT.
  - S_BOOT -> S_RUN unconditionally on the first non-reset edge. fetch_valid=1 from that edge on.
  - S_RUN: retire when fire = exec_valid & ~stall.
  - S_HALT: pc frozen, fetch_valid=0, halted=1, exec_valid/stall ignored. Exit only via reset.
- Jump condition, combinational:
  - taken = is_c_inst & ((j1&ng) | (j2&zr) | (j3&~ng&~zr)).
  - jump_bits=111 is unconditional; 000 never jumps.
  - A-instructions (is_c_inst=0) never jump regardless of jump_bits.
- On fire in S_RUN:
  - taken & (a_in == pc) -> S_HALT. pc unchanged, halted<=1, fetch_valid<=0, jump_taken<=1, retired increments.
  - taken otherwise -> pc<=a_in, jump_taken<=1.
  - not taken -> pc<=pc+1 modulo 2^WIDTH (0xFFFF -> 0x0000, no flag), jump_taken<=0.
  - retired<=retired+1, holding at all-ones (no wrap).
- No fire (stall=1 or exec_valid=0):
  - pc, retired and state hold; jump_taken<=0.
  - stall has priority over exec_valid.
- jump_taken is a registered pulse: high exactly one cycle after the retiring edge of a taken jump.
- exec_valid in S_BOOT or S_HALT is ignored: no pc change, no count.
- Latency: pc reflects a retire one clock after the fire edge. Flags zr/ng are sampled in the same cycle as exec_valid.
- Reset asserted mid-stall or in S_HALT: full reinit as above on that edge.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Assert reset 2 cycles, release -> pc=0x0000, fetch_valid=0 for 1 cycle then 1, retired=0, halted=0.
- Retire 5 A-instructions (is_c_inst=0, jump_bits=111) -> pc steps 0,1,2,3,4,5; jump_taken never set; retired=5.
- pc=0x0010, C-inst jump_bits=010, zr=1, a_in=0x0100 -> pc=0x0100 next cycle, jump_taken=1 one cycle. Repeat with zr=0, ng=1 -> pc=0x0011.
- Walk all 8 jump_bits codes against flag triples (zr,ng)=(1,0),(0,1),(0,0) -> taken matches the JGT/JEQ/JGE/JLT/JNE/JLE/JMP truth table, 24 cases.
- Hold stall=1 with exec_valid=1 for 3 cycles at pc=0x0020 -> pc and retired unchanged; release -> pc=0x0021. pc=0xFFFF not-taken -> pc=0x0000.
- pc=0x0030, a_in=0x0030, jump_bits=111 -> halted=1, fetch_valid=0, pc stays 0x0030 for 10 cycles despite exec_valid. Assert reset -> pc=0, halted=0. Preload retired near all-ones (CNT_WIDTH=4 build) -> saturates at 0xF.
